o_writeback: RTL and testbench

O_WRITEBACK -- requirements
Module: o_writeback

---
 rtl/o_writeback_pkg.sv | 22 ++
 rtl/o_word_pack.sv | 36 +++
 rtl/o_writeback.sv | 169 ++++++++++++++++
 tb/tb_o_writeback.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/o_writeback_pkg.sv
// ---------------------------------------------------------------------------
// o_writeback_pkg
// Shared types and constants for the O-vector writeback path.
//   ELEM_W            : width of one O-vector element
//   MAX_EMBEDDING_DIM : number of elements in one O-vector
//   o_vector_t        : packed O-vector, element 0 in the LSBs
//   clog2_min1()      : counter width helper that never returns 0
// ---------------------------------------------------------------------------
package o_writeback_pkg;

    localparam int ELEM_W            = 8;
    localparam int MAX_EMBEDDING_DIM = 16;

    typedef logic [MAX_EMBEDDING_DIM-1:0][ELEM_W-1:0] o_vector_t;

    // Width needed to count 0..n-1, but at least one bit so that a
    // degenerate size still yields a legal vector declaration.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/o_word_pack.sv
// ---------------------------------------------------------------------------
// o_word_pack
// Combinational slicer that selects one SRAM word out of an O-vector.
// Word b holds elements b*ELEMS_PER_WORD .. b*ELEMS_PER_WORD+ELEMS_PER_WORD-1,
// with the lowest-numbered element in the LSBs.
// Ports:
//   vec  (in)  : buffered O-vector
//   beat (in)  : word index within the vector
//   word (out) : packed write word
// ---------------------------------------------------------------------------
module o_word_pack
    import o_writeback_pkg::*;
#(
    parameter int ELEMS_PER_WORD = 4,
    parameter int BEAT_W         = 2
) (
    input  o_vector_t                                 vec,
    input  logic [BEAT_W-1:0]                         beat,
    output logic [ELEMS_PER_WORD-1:0][ELEM_W-1:0]     word
);

    localparam int IDX_W = clog2_min1(MAX_EMBEDDING_DIM);

    // Gather ELEMS_PER_WORD consecutive elements starting at the beat's
    // first element; the index is narrowed to the vector's own index width.
    always_comb begin
        logic [IDX_W-1:0] idx;
        word = '0;
        idx  = '0;
        for (int e = 0; e < ELEMS_PER_WORD; e++) begin
            idx     = IDX_W'(int'(beat) * ELEMS_PER_WORD + e);
            word[e] = vec[idx];
        end
    end

endmodule

// File: rtl/o_writeback.sv
// ---------------------------------------------------------------------------
// o_writeback
// Receives scaled O-vectors from the PE one at a time and writes each one to
// the O SRAM as BEATS consecutive words, starting at a base address latched
// on start. Rows are laid out contiguously: address = base + row*BEATS + beat
// (wrapping modulo 2^ADDR_W). The next vector can be taken on the final beat
// of the current one, so a continuous stream produces one word every cycle.
// Ports:
//   clk        (in)  : system clock, rising edge
//   rst        (in)  : asynchronous active-low reset
//   start      (in)  : arms a pass when idle
//   base_addr  (in)  : first SRAM address of the pass, sampled on start
//   vld_in     (in)  : PE has an output vector
//   rdy_out    (out) : we can take a vector this cycle
//   vec_in     (in)  : the output vector
//   sram_we    (out) : SRAM write enable
//   sram_addr  (out) : SRAM write address
//   sram_wdata (out) : SRAM write word, element 0 in the LSBs
//   busy       (out) : pass in progress (any state but IDLE)
//   done       (out) : one-cycle pulse at end of pass
// ---------------------------------------------------------------------------
module o_writeback
    import o_writeback_pkg::*;
#(
    parameter int NUM_ROWS       = 64,
    parameter int ELEMS_PER_WORD = 4,
    parameter int ADDR_W         = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [ADDR_W-1:0]                  base_addr,
    input  logic                               vld_in,
    output logic                               rdy_out,
    input  o_vector_t                          vec_in,
    output logic                               sram_we,
    output logic [ADDR_W-1:0]                  sram_addr,
    output logic [ELEMS_PER_WORD*ELEM_W-1:0]   sram_wdata,
    output logic                               busy,
    output logic                               done
);

    localparam int BEATS       = MAX_EMBEDDING_DIM / ELEMS_PER_WORD;
    localparam int BEAT_W      = clog2_min1(BEATS);
    localparam int ROW_W       = clog2_min1(NUM_ROWS + 1);
    localparam bit SINGLE_BEAT = (BEATS == 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [ROW_W-1:0]    row_q;
    logic [BEAT_W-1:0]   beat_q;
    o_vector_t           buf_q;

    logic                transfer;
    logic                last_beat;
    logic                next_is_last;
    logic                more_rows;
    logic                more_after_next;

    // Handshake and beat/row bookkeeping used by the state machine.
    // more_rows: the row being written is not the last one, so another vector
    // may still be accepted. more_after_next: same question one row ahead,
    // needed when a back-to-back vector starts a new row.
    assign transfer        = vld_in & rdy_out;
    assign last_beat       = (int'(beat_q) == BEATS - 1);
    assign next_is_last    = (int'(beat_q) + 2 == BEATS);
    assign more_rows       = (int'(row_q) + 1 < NUM_ROWS);
    assign more_after_next = (int'(row_q) + 2 < NUM_ROWS);

    // Rows are contiguous in SRAM, so the address is a straight offset from
    // the latched base; truncation to ADDR_W gives the silent wrap.
    assign sram_addr = base_q + ADDR_W'(int'(row_q) * BEATS + int'(beat_q));

    o_word_pack #(
        .ELEMS_PER_WORD (ELEMS_PER_WORD),
        .BEAT_W         (BEAT_W)
    ) u_pack (
        .vec  (buf_q),
        .beat (beat_q),
        .word (sram_wdata)
    );

    // Main state machine. All handshake/status outputs are registered, so
    // each transition also sets the values those outputs must show in the
    // next state. rdy_out is raised one cycle early for the final beat so a
    // new vector lands exactly as the last word of the previous one goes out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            base_q  <= '0;
            row_q   <= '0;
            beat_q  <= '0;
            buf_q   <= '0;
            rdy_out <= 1'b0;
            sram_we <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        row_q   <= '0;
                        beat_q  <= '0;
                        state   <= RECV;
                        rdy_out <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                RECV: begin
                    if (transfer) begin
                        buf_q   <= vec_in;
                        beat_q  <= '0;
                        state   <= WRITE;
                        sram_we <= 1'b1;
                        rdy_out <= SINGLE_BEAT && more_rows;
                    end
                end

                WRITE: begin
                    if (!last_beat) begin
                        beat_q  <= beat_q + 1'b1;
                        rdy_out <= next_is_last && more_rows;
                    end else begin
                        row_q  <= row_q + 1'b1;
                        beat_q <= '0;
                        if (!more_rows) begin
                            state   <= DONE;
                            sram_we <= 1'b0;
                            rdy_out <= 1'b0;
                            done    <= 1'b1;
                        end else if (transfer) begin
                            buf_q   <= vec_in;
                            state   <= WRITE;
                            sram_we <= 1'b1;
                            rdy_out <= SINGLE_BEAT && more_after_next;
                        end else begin
                            state   <= RECV;
                            sram_we <= 1'b0;
                            rdy_out <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    rdy_out <= 1'b0;
                    sram_we <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_o_writeback.sv
// ---------------------------------------------------------------------------
// tb_o_writeback
// Self-checking bench for o_writeback (NUM_ROWS=3, four words per vector,
// 10-bit addresses). A queue-based model predicts the write stream and the
// handshake/status outputs every cycle; directed sequences add literal
// checks for single-row writes, gaps, back-to-back streaming, address wrap,
// ignored restarts and reset in the middle of a pass.
// ---------------------------------------------------------------------------
module tb_o_writeback;
    import o_writeback_pkg::*;

    localparam int NUM_ROWS = 3;
    localparam int EPW      = 4;
    localparam int ADDR_W   = 10;
    localparam int BEATS    = MAX_EMBEDDING_DIM / EPW;
    localparam int WORD_W   = EPW * ELEM_W;

    logic               clk       = 1'b0;
    logic               rst       = 1'b0;
    logic               start     = 1'b0;
    logic               vld_in    = 1'b0;
    logic [ADDR_W-1:0]  base_addr = '0;
    o_vector_t          vec_in    = '0;
    logic               rdy_out;
    logic               sram_we;
    logic [ADDR_W-1:0]  sram_addr;
    logic [WORD_W-1:0]  sram_wdata;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    o_writeback #(
        .NUM_ROWS       (NUM_ROWS),
        .ELEMS_PER_WORD (EPW),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .vld_in     (vld_in),
        .rdy_out    (rdy_out),
        .vec_in     (vec_in),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .busy       (busy),
        .done       (done)
    );

    // One comparison: count it, and report it when it does not match.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Vector whose element i holds first+i.
    function automatic o_vector_t make_vec(input int first);
        o_vector_t v;
        for (int i = 0; i < MAX_EMBEDDING_DIM; i++) v[i] = ELEM_W'(first + i);
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Model: a pass is idle / running / finishing. While running, every
    // accepted vector appends its BEATS words (address + data) to a queue,
    // and the DUT must emit the queue head each cycle it is non-empty.
    // A vector may be taken whenever at most one word is still owed and
    // the row quota is not used up.
    // ------------------------------------------------------------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] word;
    } wr_t;

    wr_t               exp_q[$];
    int                m_phase    = 0;
    int                m_accepted = 0;
    logic [ADDR_W-1:0] m_base     = '0;
    logic              exp_rdy    = 1'b0;
    logic              exp_we     = 1'b0;
    logic              exp_busy   = 1'b0;
    logic              exp_done   = 1'b0;

    task automatic modelReset();
        exp_q.delete();
        m_phase    = 0;
        m_accepted = 0;
        m_base     = '0;
        exp_rdy    = 1'b0;
        exp_we     = 1'b0;
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
    endtask

    task automatic modelStep();
        logic [MAX_EMBEDDING_DIM*ELEM_W-1:0] bits;
        wr_t w;
        bit  took;
        took = vld_in && exp_rdy;
        case (m_phase)
            0: begin
                if (start) begin
                    m_phase    = 1;
                    m_base     = base_addr;
                    m_accepted = 0;
                    exp_q.delete();
                end
            end
            1: begin
                if (exp_we) void'(exp_q.pop_front());
                if (took) begin
                    bits = vec_in;
                    for (int b = 0; b < BEATS; b++) begin
                        w.addr = m_base + ADDR_W'(m_accepted * BEATS + b);
                        w.word = bits[b*WORD_W +: WORD_W];
                        exp_q.push_back(w);
                    end
                    m_accepted++;
                end
                if (exp_q.size() == 0 && m_accepted == NUM_ROWS) m_phase = 2;
            end
            default: m_phase = 0;
        endcase
        exp_busy = (m_phase != 0);
        exp_done = (m_phase == 2);
        exp_we   = (m_phase == 1) && (exp_q.size() > 0);
        exp_rdy  = (m_phase == 1) && (m_accepted < NUM_ROWS) && (exp_q.size() <= 1);
    endtask

    // Advance the model on every rising edge and compare 1 time unit later.
    always @(posedge clk) begin
        logic in_reset;
        in_reset = !rst;
        if (in_reset) modelReset();
        else          modelStep();
        #1;
        checkOutput("cmp_rdy",  rdy_out, exp_rdy);
        checkOutput("cmp_we",   sram_we, exp_we);
        checkOutput("cmp_busy", busy,    exp_busy);
        checkOutput("cmp_done", done,    exp_done);
        if (in_reset) begin
            checkOutput("cmp_rst_addr",  sram_addr,  0);
            checkOutput("cmp_rst_wdata", sram_wdata, 0);
        end else if (exp_we) begin
            checkOutput("cmp_addr",  sram_addr,  exp_q[0].addr);
            checkOutput("cmp_wdata", sram_wdata, exp_q[0].word);
        end
    end

    // Drive one cycle of inputs at the falling edge.
    task automatic applyStimulus(input logic st, input logic [ADDR_W-1:0] ba,
                                 input logic v, input o_vector_t vec);
        @(negedge clk);
        start     = st;
        base_addr = ba;
        vld_in    = v;
        vec_in    = vec;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, base_addr, 1'b0, '0);
    endtask

    // Hold vld_in high with vec until done is seen (bounded), then check the
    // pulse is a single cycle.
    task automatic runToDone(input string name, input o_vector_t vec);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            applyStimulus(1'b0, base_addr, 1'b1, vec);
            if (done) seen = 1'b1;
        end
        checkOutput(name, 64'(seen), 1);
        applyStimulus(1'b0, base_addr, 1'b0, '0);
        checkOutput({name, "_len"}, done, 0);
        checkOutput({name, "_idle"}, busy, 0);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] addr_log [4];
        logic [15:0]       rdy_mask;
        logic [ADDR_W-1:0] first_addr, last_addr;
        int                we_cnt, first_c, last_c;

        // Reset state
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("rst_rdy",   rdy_out,    0);
        checkOutput("rst_we",    sram_we,    0);
        checkOutput("rst_busy",  busy,       0);
        checkOutput("rst_done",  done,       0);
        checkOutput("rst_addr",  sram_addr,  0);
        checkOutput("rst_wdata", sram_wdata, 0);
        rst = 1'b1;

        // Single row at 0x010, then a 5-cycle gap, then two more rows
        applyStimulus(1'b1, 10'h010, 1'b0, '0);
        applyStimulus(1'b0, 10'h010, 1'b1, make_vec(0));
        checkOutput("t1_rdy_recv", rdy_out, 1);
        checkOutput("t1_busy",     busy,    1);
        checkOutput("t1_we_recv",  sram_we, 0);
        applyStimulus(1'b0, 10'h010, 1'b0, '0);
        checkOutput("t1_we0",    sram_we,    1);
        checkOutput("t1_addr0",  sram_addr,  10'h010);
        checkOutput("t1_word0",  sram_wdata, 32'h03020100);
        applyStimulus(1'b0, 10'h010, 1'b0, '0);
        checkOutput("t1_addr1",  sram_addr,  10'h011);
        checkOutput("t1_word1",  sram_wdata, 32'h07060504);
        applyStimulus(1'b0, 10'h010, 1'b0, '0);
        checkOutput("t1_addr2",  sram_addr,  10'h012);
        checkOutput("t1_word2",  sram_wdata, 32'h0b0a0908);
        applyStimulus(1'b0, 10'h010, 1'b0, '0);
        checkOutput("t1_addr3",  sram_addr,  10'h013);
        checkOutput("t1_word3",  sram_wdata, 32'h0f0e0d0c);
        checkOutput("t1_rdy3",   rdy_out,    1);
        idleCycles(4);
        checkOutput("t1_gap_we",  sram_we, 0);
        checkOutput("t1_gap_rdy", rdy_out, 1);
        applyStimulus(1'b0, 10'h010, 1'b1, make_vec(16));
        applyStimulus(1'b0, 10'h010, 1'b0, '0);
        checkOutput("t1_row1_addr", sram_addr,  10'h014);
        checkOutput("t1_row1_word", sram_wdata, 32'h13121110);
        idleCycles(4);
        applyStimulus(1'b0, 10'h010, 1'b1, make_vec(32));
        runToDone("t1_done", make_vec(200));
        applyStimulus(1'b0, 10'h010, 1'b1, make_vec(200));
        applyStimulus(1'b0, 10'h010, 1'b1, make_vec(200));
        checkOutput("t1_idle_rdy", rdy_out, 0);
        checkOutput("t1_idle_we",  sram_we, 0);
        idleCycles(2);

        // Back-to-back stream of three rows at 0x100
        we_cnt = 0; first_c = -1; last_c = -1; rdy_mask = '0;
        first_addr = '0; last_addr = '0;
        applyStimulus(1'b1, 10'h100, 1'b1, make_vec(64));
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1'b0, 10'h100, 1'b1, make_vec(64 + c));
            if (sram_we) begin
                if (we_cnt == 0) begin
                    first_c    = c;
                    first_addr = sram_addr;
                end
                if (rdy_out && we_cnt < 16) rdy_mask[we_cnt] = 1'b1;
                we_cnt++;
                last_c    = c;
                last_addr = sram_addr;
            end
        end
        checkOutput("t2_we_count",   we_cnt,              12);
        checkOutput("t2_contiguous", last_c - first_c + 1, 12);
        checkOutput("t2_first_addr", first_addr,          10'h100);
        checkOutput("t2_last_addr",  last_addr,           10'h10B);
        checkOutput("t2_rdy_beats",  rdy_mask,            16'h0088);
        idleCycles(2);

        // Address wrap from 0x3FE
        applyStimulus(1'b1, 10'h3FE, 1'b0, '0);
        applyStimulus(1'b0, 10'h3FE, 1'b1, make_vec(100));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 10'h3FE, 1'b0, '0);
            addr_log[i] = sram_addr;
        end
        checkOutput("t3_wrap0", addr_log[0], 10'h3FE);
        checkOutput("t3_wrap1", addr_log[1], 10'h3FF);
        checkOutput("t3_wrap2", addr_log[2], 10'h000);
        checkOutput("t3_wrap3", addr_log[3], 10'h001);
        runToDone("t3_done", make_vec(120));
        idleCycles(2);

        // Restart while busy is ignored; reset during beat 2 abandons the pass
        applyStimulus(1'b1, 10'h020, 1'b0, '0);
        applyStimulus(1'b0, 10'h020, 1'b1, make_vec(50));
        applyStimulus(1'b1, 10'h200, 1'b0, '0);
        checkOutput("t4_addr_b0", sram_addr, 10'h020);
        applyStimulus(1'b0, 10'h200, 1'b0, '0);
        checkOutput("t4_start_ignored", sram_addr, 10'h021);
        applyStimulus(1'b0, 10'h200, 1'b0, '0);
        checkOutput("t4_we_b2",   sram_we,   1);
        checkOutput("t4_addr_b2", sram_addr, 10'h022);
        #2 rst = 1'b0;
        #1;
        checkOutput("t4_rst_we",    sram_we,    0);
        checkOutput("t4_rst_rdy",   rdy_out,    0);
        checkOutput("t4_rst_busy",  busy,       0);
        checkOutput("t4_rst_done",  done,       0);
        checkOutput("t4_rst_addr",  sram_addr,  0);
        checkOutput("t4_rst_wdata", sram_wdata, 0);
        idleCycles(2);
        applyStimulus(1'b0, 10'h020, 1'b1, make_vec(70));
        rst = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 10'h020, 1'b1, make_vec(70));
        checkOutput("t4_noaccept_we",   sram_we, 0);
        checkOutput("t4_noaccept_rdy",  rdy_out, 0);
        checkOutput("t4_noaccept_busy", busy,    0);
        applyStimulus(1'b1, 10'h040, 1'b1, make_vec(80));
        runToDone("t4_restart_done", make_vec(80));
        idleCycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
